// File: rtl/wb_matvec_accel.sv
// -----------------------------------------------------------------------------
// wb_matvec_accel
//   Wishbone-slave matrix-vector multiplier: y = A * x, signed fixed point.
//   Software loads A (ROWS x COLUMNS) and x (COLUMNS) through the bus, writes
//   START, and the engine performs one multiply-accumulate per cycle, writing
//   each finished row sum into y. DONE (and optionally irq_o) flags completion.
//
// Ports
//   clk        single clock for bus and datapath
//   rstn       asynchronous active-low reset
//   wbs_cyc_i  Wishbone cycle          wbs_stb_i  Wishbone strobe
//   wbs_we_i   write enable            wbs_sel_i  byte selects (all-zero = no-op write)
//   wbs_adr_i  byte address, [11:2] decoded
//   wbs_dat_i  write data              wbs_dat_o  read data (valid in ack cycle, else 0)
//   wbs_ack_o  one-cycle acknowledge   irq_o      level interrupt = DONE & IE
//
// Map: 0x000 CTRL {IE, START}  0x004 STATUS {DONE(w1c), BUSY}
//      0x100 A[r][c]  0x200 x[c]  0x300 y[r] (read-only)
// -----------------------------------------------------------------------------
module wb_matvec_accel #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int WIDTH   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int NEL  = ROWS * COLUMNS;
    localparam int ACCW = 2 * WIDTH + $clog2(COLUMNS);
    localparam int CW   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW   = (NEL > 1) ? $clog2(NEL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_nxt;

    // Storage: A is kept flat in row-major order so the MAC walks it with a
    // single running index instead of computing r*COLUMNS+c.
    logic [NEL-1:0][WIDTH-1:0]  a_mem;
    logic [COLUMNS-1:0][WIDTH-1:0] x_mem;
    logic [ROWS-1:0][ACCW-1:0]  y_mem;

    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [AW-1:0] a_idx;
    logic signed [ACCW-1:0] acc;

    logic ie, done;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       req, wr;
    logic [3:0] region;
    logic [5:0] widx;
    logic       sel_ctrl, sel_stat, sel_a, sel_x, sel_y;
    logic       busy, start_req, clr_req;

    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr       = req & wbs_we_i & (wbs_sel_i != 4'd0);
    assign region   = wbs_adr_i[11:8];
    assign widx     = wbs_adr_i[7:2];
    assign sel_ctrl = (wbs_adr_i[11:2] == 10'd0);
    assign sel_stat = (wbs_adr_i[11:2] == 10'd1);
    assign sel_a    = (region == 4'h1) && ({1'b0, widx} < 7'(NEL));
    assign sel_x    = (region == 4'h2) && ({1'b0, widx} < 7'(COLUMNS));
    assign sel_y    = (region == 4'h3) && ({1'b0, widx} < 7'(ROWS));

    assign busy      = (state != IDLE);
    // START is only honoured from IDLE; a start while busy is acked and dropped.
    assign start_req = wr & sel_ctrl & wbs_dat_i[0] & (state == IDLE);
    assign clr_req   = wr & sel_stat & wbs_dat_i[1];

    assign irq_o = done & ie;

    // Address bits above the decoded window and byte offset are don't-care.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:12], wbs_adr_i[1:0], wbs_dat_i};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic last_col, last_row;

    assign last_col = (col_cnt == CW'(COLUMNS - 1));
    assign last_row = (row_cnt == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = RUN;
            RUN:     if (last_col && last_row) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // MAC operand select and arithmetic
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0]   a_op, x_op;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    acc_nxt;

    always_comb begin
        a_op = '0;
        x_op = '0;
        for (int i = 0; i < NEL; i++)
            if (a_idx == AW'(i)) a_op = a_mem[i];
        for (int i = 0; i < COLUMNS; i++)
            if (col_cnt == CW'(i)) x_op = x_mem[i];
    end

    assign prod    = a_op * x_op;
    // Accumulator carries clog2(COLUMNS) guard bits, so the sum cannot overflow.
    assign acc_nxt = acc + ACCW'(prod);

    // ------------------------------------------------------------------
    // Datapath, storage and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_mem   <= '0;
            x_mem   <= '0;
            y_mem   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            a_idx   <= '0;
            acc     <= '0;
            ie      <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (start_req) begin
                row_cnt <= '0;
                col_cnt <= '0;
                a_idx   <= '0;
                acc     <= '0;
            end else if (state == RUN) begin
                a_idx <= a_idx + AW'(1);
                if (last_col) begin
                    // Row finished: commit the full sum and restart the accumulator.
                    for (int i = 0; i < ROWS; i++)
                        if (row_cnt == RW'(i)) y_mem[i] <= acc_nxt;
                    acc     <= '0;
                    col_cnt <= '0;
                    row_cnt <= row_cnt + RW'(1);
                end else begin
                    acc     <= acc_nxt;
                    col_cnt <= col_cnt + CW'(1);
                end
            end

            // Operand writes are locked out while the engine is reading them.
            if (wr && !busy) begin
                if (sel_a)
                    for (int i = 0; i < NEL; i++)
                        if (widx == 6'(i)) a_mem[i] <= wbs_dat_i[WIDTH-1:0];
                if (sel_x)
                    for (int i = 0; i < COLUMNS; i++)
                        if (widx == 6'(i)) x_mem[i] <= wbs_dat_i[WIDTH-1:0];
            end

            if (wr && sel_ctrl) ie <= wbs_dat_i[1];

            // Completion beats a simultaneous software clear.
            if (state == FIN)   done <= 1'b1;
            else if (start_req) done <= 1'b0;
            else if (clr_req)   done <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    logic [31:0]             rdata;
    logic signed [WIDTH-1:0] a_t, x_t;
    logic signed [ACCW-1:0]  y_t;

    always_comb begin
        rdata = 32'd0;
        a_t   = '0;
        x_t   = '0;
        y_t   = '0;
        if (sel_ctrl) begin
            rdata = {30'd0, ie, 1'b0};
        end else if (sel_stat) begin
            rdata = {30'd0, done, busy};
        end else if (sel_a) begin
            for (int i = 0; i < NEL; i++)
                if (widx == 6'(i)) a_t = a_mem[i];
            rdata = 32'(a_t);
        end else if (sel_x) begin
            for (int i = 0; i < COLUMNS; i++)
                if (widx == 6'(i)) x_t = x_mem[i];
            rdata = 32'(x_t);
        end else if (sel_y) begin
            for (int i = 0; i < ROWS; i++)
                if (widx == 6'(i)) y_t = y_mem[i];
            rdata = 32'(y_t);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_matvec_accel.sv
// -----------------------------------------------------------------------------
// tb_wb_matvec_accel
//   Directed self-checking bench for wb_matvec_accel (4x4, 8-bit defaults).
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_wb_matvec_accel;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    always #5 clk = ~clk;

    wb_matvec_accel #(.ROWS(4), .COLUMNS(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .irq_o     (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Cycle counter and irq rising-edge monitor for latency checks.
    int   cyc_cnt   = 0;
    int   irq_rises = 0;
    int   t_rise    = 0;
    logic irq_q     = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (irq === 1'b1 && irq_q !== 1'b1) begin
            irq_rises++;
            t_rise = cyc_cnt;
        end
        irq_q = irq;
    end

    function automatic logic [11:0] a_addr(input int r, input int c);
        return 12'(256 + 4 * (r * 4 + c));
    endfunction
    function automatic logic [11:0] x_addr(input int c);
        return 12'(512 + 4 * c);
    endfunction
    function automatic logic [11:0] y_addr(input int r);
        return 12'(768 + 4 * r);
    endfunction

    // One Wishbone access; returns at the negedge of the ack cycle.
    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {20'd0, a}; dat = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("ack@%03h", a), {31'd0, ack}, 32'd1);
        rd  = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; dat = 32'd0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, a, d, 4'hF, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, a, 32'd0, 4'hF, rd);
        chk(tag, rd, exp);
    endtask

    task automatic load_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(a_addr(r, c), (r == c) ? 32'd1 : 32'd0);
        for (int c = 0; c < 4; c++)
            wr(x_addr(c), 32'(c + 1));
    endtask

    // START with IE set, wait well past completion, confirm DONE, then clear it.
    task automatic run_and_clear();
        wr(12'h000, 32'h3);
        repeat (24) @(negedge clk);
        rd_chk("run_done", 12'h004, 32'h2);
        wr(12'h004, 32'h2);
    endtask

    int t_start;
    int rises0;

    initial begin
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
        rstn = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        rd_chk("rst_status", 12'h004, 32'h0);
        rd_chk("rst_ctrl",   12'h000, 32'h0);
        rd_chk("rst_y0",     y_addr(0), 32'h0);
        rd_chk("rst_a23",    a_addr(2, 3), 32'h0);

        // Identity matrix, x = 1..4, with latency measurement.
        wr(12'h000, 32'h2);
        load_identity();
        rd_chk("x3", x_addr(3), 32'd4);
        rises0 = irq_rises;
        wr(12'h000, 32'h3);
        t_start = cyc_cnt;
        rd_chk("busy", 12'h004, 32'h1);
        repeat (25) @(negedge clk);
        chk("done_latency", 32'(t_rise - t_start), 32'd17);
        chk("done_once", 32'(irq_rises - rises0), 32'd1);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd_chk("status_done", 12'h004, 32'h2);
        for (int r = 0; r < 4; r++)
            rd_chk($sformatf("id_y%0d", r), y_addr(r), 32'(r + 1));
        wr(12'h004, 32'h2);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("status_clr", 12'h004, 32'h0);

        // Extreme negative operands.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(a_addr(r, c), 32'hFFFF_FF80);
        for (int c = 0; c < 4; c++)
            wr(x_addr(c), 32'h0000_0080);
        rd_chk("a12_sext", a_addr(1, 2), 32'hFFFF_FF80);
        rd_chk("x0_sext",  x_addr(0), 32'hFFFF_FF80);
        run_and_clear();
        for (int r = 0; r < 4; r++)
            rd_chk($sformatf("neg_y%0d", r), y_addr(r), 32'h0001_0000);
        for (int c = 0; c < 4; c++)
            wr(a_addr(0, c), 32'd127);
        run_and_clear();
        rd_chk("mix_y0", y_addr(0), 32'hFFFF_0200);
        rd_chk("mix_y1", y_addr(1), 32'h0001_0000);

        // Writes while busy are acked but ignored.
        load_identity();
        rises0 = irq_rises;
        wr(12'h000, 32'h3);
        t_start = cyc_cnt;
        wr(a_addr(0, 0), 32'd5);
        wr(12'h000, 32'h3);
        repeat (25) @(negedge clk);
        chk("busy_latency", 32'(t_rise - t_start), 32'd17);
        chk("busy_once", 32'(irq_rises - rises0), 32'd1);
        rd_chk("busy_y0", y_addr(0), 32'd1);
        rd_chk("busy_y3", y_addr(3), 32'd4);
        rd_chk("busy_a00", a_addr(0, 0), 32'd1);
        wr(12'h004, 32'h2);

        // DONE-clear colliding with DONE-set: set wins.
        wr(12'h000, 32'h3);
        repeat (16) @(posedge clk);
        wr(12'h004, 32'h2);
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        rd_chk("set_wins_st", 12'h004, 32'h2);
        wr(12'h000, 32'h0);
        chk("ie_off_irq", {31'd0, irq}, 32'd0);
        wr(12'h000, 32'h2);
        chk("ie_on_irq", {31'd0, irq}, 32'd1);
        wr(12'h004, 32'h2);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        rd_chk("persist_y2", y_addr(2), 32'd3);

        // Unmapped accesses and zero byte-select write.
        rd_chk("unmap_rd", 12'h3FC, 32'h0);
        wr(12'h080, 32'hFFFF_FFFF);
        rd_chk("unmap_ctrl", 12'h000, 32'h2);
        rd_chk("unmap_st",   12'h004, 32'h0);
        @(negedge clk);
        chk("idle_ack", {31'd0, ack}, 32'd0);
        chk("idle_dat", dat_o, 32'd0);
        begin
            logic [31:0] rd;
            xfer(1'b1, a_addr(1, 1), 32'h33, 4'h0, rd);
        end
        rd_chk("sel0_a11", a_addr(1, 1), 32'd1);

        // Reset in the middle of a run.
        wr(12'h000, 32'h3);
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_dat", dat_o, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rd_chk("midrst_st",  12'h004, 32'h0);
        rd_chk("midrst_ctrl", 12'h000, 32'h0);
        rd_chk("midrst_y0",  y_addr(0), 32'h0);
        rd_chk("midrst_y3",  y_addr(3), 32'h0);
        rd_chk("midrst_a00", a_addr(0, 0), 32'h0);
        rd_chk("midrst_x0",  x_addr(0), 32'h0);
        wr(a_addr(1, 0), 32'd3);
        wr(x_addr(0), 32'd7);
        run_and_clear();
        rd_chk("post_y0", y_addr(0), 32'd0);
        rd_chk("post_y1", y_addr(1), 32'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_matvec_accel.md
WB_MATVEC_ACCEL -- requirements
Module: wb_matvec_accel

Interface
REQ-001 Parameter ROWS, default 4: matrix rows and result count; 1..8.
REQ-002 Parameter COLUMNS, default 4: matrix columns and vector length; 1..8.
REQ-003 Parameter WIDTH, default 8: signed element width; 2*WIDTH+clog2(COLUMNS) SHALL be <=32.
REQ-004 clk  in  1  single clock for bus and datapath; the block SHALL use one clock only.
REQ-005 rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 wbs_cyc_i  in  1  Wishbone cycle.
REQ-007 wbs_stb_i  in  1  Wishbone strobe.
REQ-008 wbs_we_i  in  1  write enable.
REQ-009 wbs_sel_i  in  4  byte selects.
REQ-010 wbs_adr_i  in  32  byte address; only bits [11:0] decoded.
REQ-011 wbs_dat_i  in  32  write data.
REQ-012 wbs_ack_o  out  1  transfer acknowledge.
REQ-013 wbs_dat_o  out  32  read data.
REQ-014 irq_o  out  1  level interrupt, done AND irq enable.

Function
REQ-015 Address map: 0x000 CTRL (bit0 START write-1, bit1 IE r/w); 0x004 STATUS (bit0 BUSY ro, bit1 DONE, write-1-to-clear); 0x100+4*(r*COLUMNS+c) matrix A[r][c]; 0x200+4*c vector x[c]; 0x300+4*r result y[r] (ro).
REQ-016 Ack: wbs_ack_o SHALL assert the cycle after cyc&stb&!ack, for exactly one cycle; every access, mapped or not, is acked.
REQ-017 Element writes store wbs_dat_i[WIDTH-1:0]; writes with wbs_sel_i==0 SHALL have no effect.
REQ-018 Reads of A/x return the element sign-extended to 32 bits; y sign-extended to 32 bits; unmapped reads return 0; unmapped writes ignored.
REQ-019 wbs_dat_o SHALL be valid in the ack cycle, 0 otherwise.
REQ-020 FSM states IDLE, RUN, FIN; reset state IDLE.
REQ-021 IDLE->RUN when a CTRL write with bit0=1 is acked; DONE cleared and row/col counters zeroed in the same edge.
REQ-022 RUN: one MAC per cycle, acc += A[r][c]*x[c], c incrementing 0..COLUMNS-1, then r incrementing.
REQ-023 At c==COLUMNS-1 the final sum SHALL be written to y[r] and acc cleared in the same edge.
REQ-024 RUN->FIN after the MAC of r=ROWS-1, c=COLUMNS-1; FIN->IDLE next cycle, setting DONE.
REQ-025 BUSY SHALL be 1 in RUN and FIN; a start written at cycle T gives BUSY at T+1 and DONE visible at T+ROWS*COLUMNS+2.
REQ-026 Arithmetic: signed two's complement; product 2*WIDTH bits; accumulator 2*WIDTH+clog2(COLUMNS) bits, no saturation, no overflow possible.
REQ-027 While BUSY: START writes and A/x writes SHALL be acked and ignored; IE and DONE-clear writes take effect; y reads return current register contents.
REQ-028 DONE-clear write and FSM setting DONE in the same cycle: set wins.
REQ-029 Results in y persist until overwritten by a later run or reset.

Reset
REQ-030 rstn low SHALL asynchronously force IDLE, counters 0, acc 0, A, x, y all 0, IE 0, DONE 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0.
REQ-031 Reset mid-RUN SHALL abort the computation with no partial result retained; first access after release completes normally.

Verification
REQ-032 A=identity 4x4, x=[1,2,3,4], START -> DONE at T+18, y reads 1,2,3,4.
REQ-033 All A=-128, all x=-128 -> every y reads 0x00010000; row 0 of A=127 with x=-128 -> y[0]=0xFFFF0200.
REQ-034 START, then write A[0][0]=5 and a second START while BUSY -> both acked, no effect; results match the pre-write matrix and DONE asserts once at T+18.
REQ-035 IE=1, run completes -> irq_o=1 until STATUS write 0x2; write 0x2 on the cycle DONE sets -> DONE stays 1.
REQ-036 rstn low at T+7 of a run -> all outputs 0 immediately, y and A read 0 after release, new run works.
REQ-037 Read 0x3FC and write 0x080 -> ack next cycle, read data 0, no state change; write with wbs_sel_i=0 to A[1][1] -> value unchanged.
